// File: rtl/fp_mul_round.sv
// fp_mul_round: normalise, round-to-nearest-even and pack a raw binary32
// significand product. Two register stages (normalise, round/pack) share
// one global stall so the pipeline holds at most two results.
module fp_mul_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_mant,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  // Round-to-nearest-even; returns {carry, rounded sig}. A carry means the
  // significand reached 2^24, leaving sig bits all zero.
  function automatic logic [24:0] round_rne(input logic [23:0] sig,
                                            input logic        guard,
                                            input logic        sticky);
    logic inc;
    inc = guard & (sticky | sig[0]);
    return {1'b0, sig} + {24'h0, inc};
  endfunction

  // Saturate/flush and pack; returns {overflow, underflow, inexact, result}.
  function automatic logic [34:0] pack_sat(input logic               sign,
                                           input logic               zero,
                                           input logic signed [10:0] exp,
                                           input logic [22:0]        frac,
                                           input logic               inexact);
    logic [34:0] r;
    if (zero)
      r = {3'b000, sign, 31'h0};
    else if (exp >= 11'sd255)
      r = {2'b10, inexact, sign, 8'hFF, 23'h0};
    else if (exp <= 11'sd0)
      r = {2'b01, inexact, sign, 31'h0};
    else
      r = {2'b00, inexact, sign, exp[7:0], frac};
    return r;
  endfunction

  logic                advance;
  logic signed [10:0]  exp_ext;

  logic                vld_p1_d, vld_p1_q;
  logic                sign_p1_d, sign_p1_q;
  logic                zero_p1_d, zero_p1_q;
  logic signed [10:0]  exp_p1_d, exp_p1_q;
  logic [23:0]         sig_p1_d, sig_p1_q;
  logic                guard_p1_d, guard_p1_q;
  logic                sticky_p1_d, sticky_p1_q;

  logic [24:0]         rnd_p2;
  logic signed [10:0]  exp_r_p2;
  logic [34:0]         packed_p2;
  logic                vld_p2_d, vld_p2_q;
  logic [31:0]         result_p2_d, result_p2_q;
  logic [2:0]          flags_p2_d, flags_p2_q;

  // Whole pipeline moves together whenever the output slot is free or drains.
  assign advance   = ~vld_p2_q | out_ready;
  assign in_ready  = advance;
  assign exp_ext   = {in_exp[9], in_exp};

  // ---- Stage 1: normalise the product to a 24-bit significand + guard/sticky
  // Next-state for stage 1; everything holds while stalled.
  always_comb begin
    vld_p1_d    = vld_p1_q;
    sign_p1_d   = sign_p1_q;
    zero_p1_d   = zero_p1_q;
    exp_p1_d    = exp_p1_q;
    sig_p1_d    = sig_p1_q;
    guard_p1_d  = guard_p1_q;
    sticky_p1_d = sticky_p1_q;
    if (advance) begin
      vld_p1_d  = in_valid;
      sign_p1_d = in_sign;
      zero_p1_d = in_zero;
      if (in_mant[47]) begin
        sig_p1_d    = in_mant[47:24];
        guard_p1_d  = in_mant[23];
        sticky_p1_d = |in_mant[22:0];
        exp_p1_d    = exp_ext + 11'sd1;
      end else begin
        sig_p1_d    = in_mant[46:23];
        guard_p1_d  = in_mant[22];
        sticky_p1_d = |in_mant[21:0];
        exp_p1_d    = exp_ext;
      end
    end
  end

  // Stage 1 valid bit: cleared asynchronously so in-flight work is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= vld_p1_d;
  end

  // Stage 1 datapath registers carry no reset.
  always_ff @(posedge clk) begin
    sign_p1_q   <= sign_p1_d;
    zero_p1_q   <= zero_p1_d;
    exp_p1_q    <= exp_p1_d;
    sig_p1_q    <= sig_p1_d;
    guard_p1_q  <= guard_p1_d;
    sticky_p1_q <= sticky_p1_d;
  end

  // ---- Stage 2: round, adjust exponent on carry, saturate/flush and pack
  // Next-state for the output stage; holds result stable under backpressure.
  always_comb begin
    rnd_p2      = round_rne(sig_p1_q, guard_p1_q, sticky_p1_q);
    exp_r_p2    = exp_p1_q + (rnd_p2[24] ? 11'sd1 : 11'sd0);
    packed_p2   = pack_sat(sign_p1_q, zero_p1_q, exp_r_p2, rnd_p2[22:0],
                           guard_p1_q | sticky_p1_q);
    vld_p2_d    = vld_p2_q;
    result_p2_d = result_p2_q;
    flags_p2_d  = flags_p2_q;
    if (advance) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        result_p2_d = packed_p2[31:0];
        flags_p2_d  = packed_p2[34:32];
      end
    end
  end

  // Output registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q    <= 1'b0;
      result_p2_q <= 32'h0;
      flags_p2_q  <= 3'b000;
    end else begin
      vld_p2_q    <= vld_p2_d;
      result_p2_q <= result_p2_d;
      flags_p2_q  <= flags_p2_d;
    end
  end

  assign out_valid  = vld_p2_q;
  assign out_result = result_p2_q;
  assign out_flags  = flags_p2_q;

endmodule

// File: tb/tb_fp_mul_round.sv
// Directed bench for fp_mul_round with hand-computed binary32 results.
module tb_fp_mul_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int errors = 0;
  int checks = 0;

  fp_mul_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m, input logic z);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_zero  = z;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transfer into an empty pipeline with out_ready=1; result must
  // be absent after the first edge and present after the second.
  task automatic run_one(input string tag, input logic s, input logic [9:0] e,
                         input logic [47:0] m, input logic z,
                         input logic [31:0] res, input logic [2:0] fl);
    drive(s, e, m, z);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {63'h0, out_valid}, 64'h0);
    tick();
    chk({tag, "_valid"}, {63'h0, out_valid}, 64'h1);
    chk({tag, "_res"}, {32'h0, out_result}, {32'h0, res});
    chk({tag, "_flags"}, {61'h0, out_flags}, {61'h0, fl});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 10'd0;
    in_mant   = 48'h0;
    in_zero   = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_result", {32'h0, out_result}, 64'h0);
    chk("rst_flags", {61'h0, out_flags}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact results and rounding
    run_one("v3p75", 1'b0, 10'd128, 48'h780000000000, 1'b0, 32'h40700000, 3'b000);
    run_one("carry", 1'b0, 10'd127, 48'hFFFFFF800000, 1'b0, 32'h40800000, 3'b001);
    run_one("tie_even", 1'b0, 10'd127, 48'h400000400000, 1'b0, 32'h3F800000, 3'b001);
    run_one("tie_odd", 1'b0, 10'd127, 48'h400000C00000, 1'b0, 32'h3F800002, 3'b001);
    run_one("above_half", 1'b0, 10'd127, 48'h400000400001, 1'b0, 32'h3F800001, 3'b001);
    // Exponent boundaries
    run_one("ovf", 1'b0, 10'd254, 48'h800000000000, 1'b0, 32'h7F800000, 3'b100);
    run_one("max_norm", 1'b0, 10'd254, 48'h400000000000, 1'b0, 32'h7F000000, 3'b000);
    run_one("ovf_wide", 1'b1, 10'd511, 48'h800000000001, 1'b0, 32'hFF800000, 3'b101);
    run_one("unf", 1'b1, 10'd0, 48'h400000000000, 1'b0, 32'h80000000, 3'b010);
    run_one("min_norm", 1'b0, 10'd1, 48'h400000000000, 1'b0, 32'h00800000, 3'b000);
    run_one("unf_neg", 1'b0, 10'h3FB, 48'h400000000000, 1'b0, 32'h00000000, 3'b010);
    run_one("zero", 1'b1, 10'd200, 48'hFFFFFFFFFFFF, 1'b1, 32'h80000000, 3'b000);

    // Back-to-back transfers appear on consecutive cycles
    drive(1'b1, 10'd129, 48'h500000000000, 1'b0);
    tick();
    drive(1'b0, 10'd129, 48'h600000000000, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("b2b_first", {31'h0, out_valid, out_result}, {31'h0, 1'b1, 32'hC0A00000});
    tick();
    chk("b2b_second", {31'h0, out_valid, out_result}, {31'h0, 1'b1, 32'h40C00000});
    tick();
    chk("b2b_empty", {63'h0, out_valid}, 64'h0);

    // Backpressure: two accepted, third refused, then ordered drain
    out_ready = 1'b0;
    drive(1'b0, 10'd128, 48'h780000000000, 1'b0);
    tick();
    drive(1'b1, 10'd129, 48'h500000000000, 1'b0);
    chk("bp_ready2", {63'h0, in_ready}, 64'h1);
    tick();
    drive(1'b0, 10'd129, 48'h600000000000, 1'b0);
    chk("bp_full", {63'h0, in_ready}, 64'h0);
    chk("bp_head", {31'h0, out_valid, out_result}, {31'h0, 1'b1, 32'h40700000});
    tick();
    tick();
    chk("bp_hold", {31'h0, out_valid, out_result}, {31'h0, 1'b1, 32'h40700000});
    chk("bp_still_full", {63'h0, in_ready}, 64'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_drain2", {31'h0, out_valid, out_result}, {31'h0, 1'b1, 32'hC0A00000});
    tick();
    chk("bp_drained", {63'h0, out_valid}, 64'h0);

    // Reset with two results in flight
    out_ready = 1'b0;
    drive(1'b0, 10'd128, 48'h780000000000, 1'b0);
    tick();
    drive(1'b1, 10'd129, 48'h500000000000, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mid_full", {63'h0, out_valid}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_rst_result", {32'h0, out_result}, 64'h0);
    chk("mid_rst_ready", {63'h0, in_ready}, 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_empty1", {63'h0, out_valid}, 64'h0);
    tick();
    chk("post_rst_empty2", {63'h0, out_valid}, 64'h0);
    run_one("post_rst", 1'b0, 10'd129, 48'h600000000000, 1'b0, 32'h40C00000, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_round.md
FP_MUL_ROUND -- requirements
Module: fp_mul_round

Interface
REQ-001 Parameters: none; the block is fixed to IEEE 754 binary32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  raw product present on in_* this cycle.
REQ-005 in_ready  output  1  block accepts raw product this cycle.
REQ-006 in_sign  input  1  result sign (sign_a XOR sign_b).
REQ-007 in_exp  input  10  signed two's-complement biased exponent, exp_a + exp_b - 127.
REQ-008 in_mant  input  48  unsigned product of the two 24-bit significands with hidden bits.
REQ-009 in_zero  input  1  either operand is zero; forces a signed-zero result.
REQ-010 out_valid  output  1  out_result and out_flags hold a finished result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 out_result  output  32  packed binary32 result {sign, exp[7:0], frac[22:0]}.
REQ-013 out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-014 The block is a 2-stage pipeline: S1 normalises and S2 rounds/packs; latency is 2 cycles from the in_valid&in_ready edge to out_valid when there is no backpressure.
REQ-015 Transfer at an input or output occurs only on a cycle where valid and ready are both high.
REQ-016 Global stall: advance = ~out_valid | out_ready; in_ready = advance; both stages hold all registers while advance=0.
REQ-017 Maximum occupancy is 2 results; full throughput is 1 result/cycle while out_ready=1.
REQ-018 S1 normalisation: if in_mant[47]=1, sig=in_mant[47:24], guard=in_mant[23], sticky=OR(in_mant[22:0]), exp=in_exp+1.
REQ-019 S1 normalisation otherwise: sig=in_mant[46:23], guard=in_mant[22], sticky=OR(in_mant[21:0]), exp=in_exp.
REQ-020 S2 rounding is round-to-nearest-even: increment sig when guard & (sticky | sig[0]).
REQ-021 If the increment carries sig to 2^24, then frac=0 and exp=exp+1.
REQ-022 inexact = guard | sticky; it is reported even when the result overflows or underflows.
REQ-023 Overflow: if the final exp >= 255, out_result = {sign, 8'hFF, 23'h0} and the overflow flag = 1.
REQ-024 Underflow: if the final exp <= 0, out_result = {sign, 31'h0} and the underflow flag = 1; there is no subnormal output (flush-to-zero).
REQ-025 in_zero=1: out_result = {in_sign, 31'h0} and out_flags = 0, regardless of in_exp and in_mant.
REQ-026 Exponent arithmetic is carried at 11 bits signed internally, so that in_exp+2 cannot wrap.
REQ-027 Input precondition: in_mant[47:46] != 2'b00 whenever in_zero=0 and in_valid=1; the block does not check it.
REQ-028 out_result and out_flags are stable while out_valid=1 and out_ready=0.
REQ-029 NaN and infinity operands are out of scope and are handled upstream.

Reset
REQ-030 rst_n low asynchronously clears both stage valid bits, so out_valid=0 and in_ready=1 immediately.
REQ-031 rst_n low clears out_result to 32'h0 and out_flags to 3'b000.
REQ-032 In-flight results are discarded on reset mid-operation; the first result after release is from the first post-release transfer.
REQ-033 Datapath registers other than the outputs need no reset.

Verification
REQ-034 sign=0, exp=128, mant=48'h780000000000, out_ready=1 -> out_result=32'h40700000 (3.75) exactly 2 cycles later, flags=000.
REQ-035 sign=1, exp=129, mant=48'h500000000000 -> 32'hC0A00000; sign=0, exp=129, mant=48'h600000000000 -> 32'h40C00000; issued back-to-back, these appear on consecutive cycles.
REQ-036 Rounding carry: exp=127, mant=48'hFFFFFF800000 -> 32'h40800000, flags=001; exp=127, mant=48'h400000400000 (tie, even LSB) -> 32'h3F800000, flags=001.
REQ-037 Overflow and underflow: exp=254, mant=48'h800000000000 -> 32'h7F800000, flags=100; exp=0, mant=48'h400000000000, sign=1 -> 32'h80000000, flags=010; in_zero=1, sign=1 -> 32'h80000000, flags=000.
REQ-038 Backpressure: hold out_ready=0 and offer 3 inputs -> 2 are accepted, then in_ready=0 and out_result is held stable; raising out_ready drains both results in order with no loss or duplication.
REQ-039 Reset mid-flight: assert rst_n=0 with 2 results in flight -> out_valid=0 and out_result=0 at once; after release, only new inputs produce outputs.
